instruction_fetch_unit: RTL and testbench

// Upstream of InstructionMemory: owns the program counter and drives its word Address.

---
 rtl/instruction_fetch_unit.sv | 95 +++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and instruction stream source for decode
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            JUMP_OPCODE = 6'b000010
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectPC,
    output logic [ADDR_WIDTH-1:0] IMemAddress,
    input  logic [31:0]           IMemData,
    output logic [31:0]           Instr,
    output logic [ADDR_WIDTH-1:0] InstrPC,
    output logic                  InstrValid
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0] resp_pc, resp_pc_nxt;
    logic                  resp_valid, resp_valid_nxt;
    logic [31:0]           hold_instr, hold_instr_nxt;
    logic                  hold_valid, hold_valid_nxt;
    logic                  accept;
    logic                  is_jump;
    logic [ADDR_WIDTH-1:0] jump_target;

    assign IMemAddress = fetch_pc;
    assign InstrPC     = resp_pc;
    assign InstrValid  = resp_valid;
    // Memory keeps following fetch_pc during a stall, so the captured word is shown instead.
    assign Instr       = hold_valid ? hold_instr : IMemData;

    assign accept  = resp_valid & ~Stall;
    assign is_jump = accept & (Instr[31:26] == JUMP_OPCODE);

    generate
        if (ADDR_WIDTH > 26) begin : g_wide_jump
            always_comb begin
                jump_target        = resp_pc + PC_ONE;
                jump_target[25:0]  = Instr[25:0];
            end
        end else begin : g_narrow_jump
            assign jump_target = Instr[ADDR_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        fetch_pc_nxt   = fetch_pc;
        resp_pc_nxt    = resp_pc;
        resp_valid_nxt = resp_valid;
        hold_instr_nxt = hold_instr;
        hold_valid_nxt = hold_valid;
        if (Redirect) begin
            fetch_pc_nxt   = RedirectPC;
            resp_valid_nxt = 1'b0;
            hold_valid_nxt = 1'b0;
        end else if (Stall) begin
            if (!hold_valid && resp_valid) begin
                hold_instr_nxt = IMemData;
                hold_valid_nxt = 1'b1;
            end
        end else if (is_jump) begin
            // The word fetched behind the jump is squashed, leaving one bubble.
            fetch_pc_nxt   = jump_target;
            resp_pc_nxt    = fetch_pc;
            resp_valid_nxt = 1'b0;
            hold_valid_nxt = 1'b0;
        end else begin
            resp_pc_nxt    = fetch_pc;
            resp_valid_nxt = 1'b1;
            fetch_pc_nxt   = fetch_pc + PC_ONE;
            hold_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
            hold_instr <= '0;
            hold_valid <= 1'b0;
        end else begin
            fetch_pc   <= fetch_pc_nxt;
            resp_pc    <= resp_pc_nxt;
            resp_valid <= resp_valid_nxt;
            hold_instr <= hold_instr_nxt;
            hold_valid <= hold_valid_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - vector table, reset pulse and random stream checks
module tb_instruction_fetch_unit;

    localparam int AW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Stall;
    logic          Redirect;
    logic [AW-1:0] RedirectPC;
    logic [AW-1:0] IMemAddress;
    logic [31:0]   IMemData;
    logic [31:0]   Instr;
    logic [AW-1:0] InstrPC;
    logic          InstrValid;

    int checks = 0;
    int errors = 0;

    logic [31:0] tab [256];

    instruction_fetch_unit #(
        .ADDR_WIDTH (AW),
        .RESET_PC   ('0),
        .JUMP_OPCODE(6'b000010)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IMemAddress(IMemAddress),
        .IMemData   (IMemData),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) IMemData <= tab[IMemAddress[7:0]];

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input int i);
        return 32'h2000_0000 | (i & 32'hFF);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        if (pc == 0)  return 32'h2001_0001;
        if (pc == 2)  return 32'hAC34_0000;
        if (pc == 10) return 32'h0800_0010;
        return dflt(int'(pc[7:0]));
    endfunction

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rpc; v.ev = ev;
        v.epc = epc; v.einstr = word_at(epc); v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        Stall = v.stall; Redirect = v.redir; RedirectPC = v.rpc;
        @(posedge Clk);
        #1;
        check($sformatf("row%0d valid", idx), {31'b0, InstrValid}, {31'b0, v.ev});
        check($sformatf("row%0d addr", idx), IMemAddress, v.eaddr);
        if (v.ev) begin
            check($sformatf("row%0d pc", idx), InstrPC, v.epc);
            check($sformatf("row%0d instr", idx), Instr, v.einstr);
        end
    endtask

    // Stream-level model: what decode sees, not how fetch builds it.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_pend;

    task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] w;
        logic [31:0] nxt;
        if (rd) begin
            m_valid = 1'b0;
            m_pend  = rpc;
        end else if (st) begin
        end else if (m_valid) begin
            w   = tab[m_pc[7:0]];
            nxt = m_pc + 1;
            if (w[31:26] == 6'b000010) begin
                m_valid = 1'b0;
                m_pend  = {nxt[31:26], w[25:0]};
            end else begin
                m_pc = nxt;
            end
        end else begin
            m_valid = 1'b1;
            m_pc    = m_pend;
        end
    endtask

    initial begin
        logic        st, rd;
        logic [31:0] rpc, w;

        for (int i = 0; i < 256; i++) tab[i] = dflt(i);
        tab[0]  = 32'h2001_0001;
        tab[2]  = 32'hAC34_0000;
        tab[10] = 32'h0800_0010;

        add(0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 1, 2);
        add(0, 0, 0, 1, 2, 3);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 1, 2, 3);
        for (int p = 3; p <= 10; p++) add(0, 0, 0, 1, p, p + 1);
        add(0, 0, 0, 0, 0, 16);
        add(0, 0, 0, 1, 16, 17);
        add(0, 0, 0, 1, 17, 18);
        add(0, 1, 16, 0, 0, 16);
        add(0, 0, 0, 1, 16, 17);
        add(0, 0, 0, 1, 17, 18);
        add(1, 0, 0, 1, 17, 18);
        add(1, 1, 40, 0, 0, 40);
        add(0, 0, 0, 1, 40, 41);
        add(0, 0, 0, 1, 41, 42);
        add(0, 1, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
        add(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        add(0, 0, 0, 1, 0, 1);

        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        #1;
        check("reset valid", {31'b0, InstrValid}, 32'd0);
        check("reset addr", IMemAddress, 32'd0);
        check("reset pc", InstrPC, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        foreach (vecs[i]) apply_row(i, vecs[i]);

        // Reset pulsed between edges must take effect without a clock.
        #1 Reset = 1'b1;
        #1;
        check("midrun reset valid", {31'b0, InstrValid}, 32'd0);
        check("midrun reset addr", IMemAddress, 32'd0);
        #1 Reset = 1'b0;
        for (int i = 0; i < 3; i++) apply_row(100 + i, vecs[i]);

        Reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(5) == 0) w[31:26] = 6'b000010;
            else if (w[31:26] == 6'b000010) w[31:26] = 6'b001000;
            tab[i] = w;
        end
        @(negedge Clk);
        Reset = 1'b0;
        m_valid = 1'b0; m_pc = '0; m_pend = '0;

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(199) == 0) begin
                Reset = 1'b1;
                #1 Reset = 1'b0;
                m_valid = 1'b0; m_pend = '0;
            end
            st  = ($urandom_range(3) == 0);
            rd  = ($urandom_range(9) == 0);
            rpc = ($urandom_range(2) == 0) ? (32'hFFFF_FFFC + $urandom_range(3)) : $urandom;
            Stall = st; Redirect = rd; RedirectPC = rpc;
            @(posedge Clk);
            #1;
            model_edge(st, rd, rpc);
            check($sformatf("rnd%0d valid", c), {31'b0, InstrValid}, {31'b0, m_valid});
            check($sformatf("rnd%0d addr", c), IMemAddress, m_valid ? m_pc + 1 : m_pend);
            if (m_valid) begin
                check($sformatf("rnd%0d pc", c), InstrPC, m_pc);
                check($sformatf("rnd%0d instr", c), Instr, tab[m_pc[7:0]]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
